// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory-access pipeline stage.
// Imported by the stage, its data-memory interface and the bench.
package mem_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     rt_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  w_mem_ena;
    logic                  w_reg_ena;
    logic                  wb_sel;
  } ex_mem_t;

  typedef struct packed {
    logic [DATA_W-1:0]     w_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  w_reg_ena;
  } mem_wb_t;

  function automatic logic is_mem_op(
    input logic w_mem_ena,
    input logic wb_sel
  );
    return w_mem_ena | wb_sel;
  endfunction

  function automatic logic [DATA_W-1:0] word_addr(
    input logic [DATA_W-1:0] a
  );
    return {a[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request bus between the MEM stage and memory.
// The request stays asserted until the cycle in which ack is seen.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage_pipe_reg.sv
// Pipeline register with hold, synchronous clear and bubble load.
// Clear wins over enable; a bubble loads the BUBBLE pattern.
module pipe_reg #(
  parameter int           W      = 1,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= bubble ? BUBBLE : d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM and MEM/WB registers plus a two-state
// data-memory FSM that stalls upstream until ack arrives.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_res,
  input  logic [DATA_W-1:0]     ex_rt_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_w_mem_ena,
  input  logic                  ex_w_reg_ena,
  input  logic                  ex_wb_sel,
  output logic                  stall,
  mem_stage_if.master           dmem,
  output logic [DATA_W-1:0]     ex_mem_alu_res,
  output logic [REG_ADDR_W-1:0] ex_mem_rd,
  output logic                  ex_mem_w_reg_ena,
  output logic [DATA_W-1:0]     wb_w_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_w_reg_ena
);

  state_t  state;
  ex_mem_t ex_in;
  ex_mem_t ex_q;
  mem_wb_t wb_in;
  mem_wb_t wb_q;
  logic    in_wait;
  logic    capture_mem;

  assign in_wait = (state == WAIT);
  assign stall   = in_wait & ~dmem.dmem_ack;

  assign capture_mem = ex_valid & ~stall
    & is_mem_op(ex_w_mem_ena, ex_wb_sel);

  // x0 writes are dropped here so forwarding never sees them
  always_comb begin
    ex_in = '0;
    ex_in.alu_res   = ex_alu_res;
    ex_in.rt_data   = ex_rt_data;
    ex_in.rd        = ex_rd;
    ex_in.w_mem_ena = ex_w_mem_ena;
    ex_in.w_reg_ena = ex_w_reg_ena & (ex_rd != '0);
    ex_in.wb_sel    = ex_wb_sel;
  end

  pipe_reg #(
    .W ($bits(ex_mem_t))
  ) u_ex_mem (
    .clk    (clk),
    .rst    (rst),
    .en     (~stall),
    .bubble (~ex_valid),
    .d      (ex_in),
    .q      (ex_q)
  );

  // In IDLE the EX/MEM slot never holds a memory op
  always_comb begin
    wb_in = '0;
    wb_in.w_data    = ex_q.alu_res;
    wb_in.rd        = ex_q.rd;
    wb_in.w_reg_ena = ex_q.w_reg_ena;
    if (in_wait) begin
      if (ex_q.wb_sel) begin
        wb_in.w_data = dmem.dmem_rdata;
      end
      if (ex_q.w_mem_ena) begin
        wb_in.w_reg_ena = 1'b0;
      end
    end
  end

  pipe_reg #(
    .W ($bits(mem_wb_t))
  ) u_mem_wb (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .bubble (stall),
    .d      (wb_in),
    .q      (wb_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (capture_mem) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (dmem.dmem_ack && !capture_mem) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = in_wait;
  assign dmem.dmem_we    = in_wait & ex_q.w_mem_ena;
  assign dmem.dmem_addr  =
    in_wait ? word_addr(ex_q.alu_res) : '0;
  assign dmem.dmem_wdata = in_wait ? ex_q.rt_data : '0;

  assign ex_mem_alu_res   = ex_q.alu_res;
  assign ex_mem_rd        = ex_q.rd;
  assign ex_mem_w_reg_ena = ex_q.w_reg_ena;

  assign wb_w_data    = wb_q.w_data;
  assign wb_rd        = wb_q.rd;
  assign wb_w_reg_ena = wb_q.w_reg_ena;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios then random
// traffic against an in-order program model with its own memory.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_res;
  logic [31:0] ex_rt_data;
  logic [4:0]  ex_rd;
  logic        ex_w_mem_ena;
  logic        ex_w_reg_ena;
  logic        ex_wb_sel;
  logic        stall;
  logic [31:0] ex_mem_alu_res;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_w_reg_ena;
  logic [31:0] wb_w_data;
  logic [4:0]  wb_rd;
  logic        wb_w_reg_ena;

  mem_stage_if dmem();

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .ex_alu_res       (ex_alu_res),
    .ex_rt_data       (ex_rt_data),
    .ex_rd            (ex_rd),
    .ex_w_mem_ena     (ex_w_mem_ena),
    .ex_w_reg_ena     (ex_w_reg_ena),
    .ex_wb_sel        (ex_wb_sel),
    .stall            (stall),
    .dmem             (dmem),
    .ex_mem_alu_res   (ex_mem_alu_res),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_w_reg_ena (ex_mem_w_reg_ena),
    .wb_w_data        (wb_w_data),
    .wb_rd            (wb_rd),
    .wb_w_reg_ena     (wb_w_reg_ena)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_exp_t;

  wb_exp_t     wbq[$];
  req_exp_t    reqq[$];
  logic [31:0] mmem[int];
  logic [31:0] rmem[int];

  int checks    = 0;
  int failures  = 0;
  int stall_cnt = 0;
  int req_cnt   = 0;
  int fixed_delay = -1;
  bit force_ack = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int w);
    return 32'h5A00_0000 ^ (32'(w) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] model_rd(input int w);
    return mmem.exists(w) ? mmem[w] : init_word(w);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    mmem[int'(a[31:2])] = v;
    rmem[int'(a[31:2])] = v;
  endtask

  // Program-order model: memory ops produce a bus request, and
  // every register write to a nonzero rd produces one writeback.
  task automatic issue(input bit v, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] rd,
                       input bit wm, input bit wr, input bit sel);
    int  w;
    bit  ok;
    ex_valid     = v;
    ex_alu_res   = alu;
    ex_rt_data   = rt;
    ex_rd        = rd;
    ex_w_mem_ena = wm;
    ex_w_reg_ena = wr;
    ex_wb_sel    = sel;
    w = int'(alu[31:2]);
    if (v) begin
      if (wm) begin
        reqq.push_back('{1'b1, {alu[31:2], 2'b00}, rt});
        mmem[w] = rt;
      end else if (sel) begin
        reqq.push_back('{1'b0, {alu[31:2], 2'b00}, rt});
        if (wr && rd != 0) wbq.push_back('{model_rd(w), rd});
      end else if (wr && rd != 0) begin
        wbq.push_back('{alu, rd});
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stall) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: stall held 64 cycles");
    end
    @(posedge clk);
    #2;
    ex_valid = 1'b0;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic responder_loop();
    int cnt = 0;
    bit busy = 1'b0;
    int w;
    forever begin
      @(posedge clk);
      #1;
      if (!dmem.dmem_req) begin
        busy = 1'b0;
        dmem.dmem_ack   = force_ack;
        dmem.dmem_rdata = force_ack ? 32'hBAD0_BAD0 : 32'h0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt = (fixed_delay >= 0) ? fixed_delay
                                   : int'($urandom_range(0, 3));
        end
        w = int'(dmem.dmem_addr[31:2]);
        if (cnt == 0) begin
          busy = 1'b0;
          dmem.dmem_ack = 1'b1;
          if (dmem.dmem_we) begin
            rmem[w] = dmem.dmem_wdata;
            dmem.dmem_rdata = $urandom;
          end else begin
            dmem.dmem_rdata = rmem.exists(w) ? rmem[w]
                                             : init_word(w);
          end
        end else begin
          cnt--;
          dmem.dmem_ack   = 1'b0;
          dmem.dmem_rdata = $urandom;
        end
      end
    end
  endtask

  task automatic monitor_loop();
    bit       busy = 1'b0;
    req_exp_t cur;
    wb_exp_t  e;
    forever begin
      @(negedge clk);
      if (stall) stall_cnt++;
      check("stall_rule", {31'b0, stall},
            {31'b0, dmem.dmem_req & ~dmem.dmem_ack});
      if (!dmem.dmem_req) begin
        busy = 1'b0;
      end else begin
        req_cnt++;
        if (!busy) begin
          if (reqq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL req_unexpected: got addr %h expected none",
                     dmem.dmem_addr);
            cur = '{dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata};
          end else begin
            cur = reqq.pop_front();
            check("req_we", {31'b0, dmem.dmem_we}, {31'b0, cur.we});
            check("req_addr", dmem.dmem_addr, cur.addr);
            check("req_wdata", dmem.dmem_wdata, cur.wdata);
          end
        end else begin
          check("req_addr_hold", dmem.dmem_addr, cur.addr);
          check("req_wdata_hold", dmem.dmem_wdata, cur.wdata);
        end
        busy = !dmem.dmem_ack;
      end
      if (wb_w_reg_ena) begin
        if (wbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected: got rd %0d data %h expected none",
                   wb_rd, wb_w_data);
        end else begin
          e = wbq.pop_front();
          check("wb_data", wb_w_data, e.data);
          check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
        end
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"}, {31'b0, dmem.dmem_req}, 32'h0);
    check({tag, "_stall"}, {31'b0, stall}, 32'h0);
    check({tag, "_wb_ena"}, {31'b0, wb_w_reg_ena}, 32'h0);
    check({tag, "_wb_data"}, wb_w_data, 32'h0);
    check({tag, "_wb_rd"}, {27'b0, wb_rd}, 32'h0);
    check({tag, "_exm_alu"}, ex_mem_alu_res, 32'h0);
  endtask

  int s0;
  int r0;
  int kind;
  logic [31:0] a;

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_alu_res = 0; ex_rt_data = 0; ex_rd = 0;
    ex_w_mem_ena = 0; ex_w_reg_ena = 0; ex_wb_sel = 0;
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = 32'h0;
    fork
      responder_loop();
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check_quiet("reset");
    check("reset_addr", dmem.dmem_addr, 32'h0);
    check("reset_we", {31'b0, dmem.dmem_we}, 32'h0);

    // ALU op: two-edge latency, no stall
    s0 = stall_cnt;
    issue(1, 32'h11, 32'h0, 5'd3, 0, 1, 0);
    check("alu_exm_res", ex_mem_alu_res, 32'h11);
    check("alu_exm_ena", {31'b0, ex_mem_w_reg_ena}, 32'h1);
    bubbles(1);
    check("alu_wb_data", wb_w_data, 32'h11);
    check("alu_wb_rd", {27'b0, wb_rd}, 32'd3);
    check("alu_wb_ena", {31'b0, wb_w_reg_ena}, 32'h1);
    check("alu_stalls", 32'(stall_cnt - s0), 32'd0);

    // Load acked after three wait cycles
    poke(32'h100, 32'hDEAD_BEEF);
    fixed_delay = 3;
    s0 = stall_cnt;
    issue(1, 32'h100, 32'h0, 5'd5, 0, 1, 1);
    check("ld_addr", dmem.dmem_addr, 32'h100);
    check("ld_req", {31'b0, dmem.dmem_req}, 32'h1);
    bubbles(1);
    check("ld_wb_data", wb_w_data, 32'hDEAD_BEEF);
    check("ld_wb_rd", {27'b0, wb_rd}, 32'd5);
    check("ld_stalls", 32'(stall_cnt - s0), 32'd3);

    // Unaligned store with immediate ack
    fixed_delay = 0;
    s0 = stall_cnt;
    issue(1, 32'h203, 32'h1234, 5'd7, 1, 1, 0);
    check("st_addr", dmem.dmem_addr, 32'h200);
    check("st_we", {31'b0, dmem.dmem_we}, 32'h1);
    check("st_wdata", dmem.dmem_wdata, 32'h1234);
    bubbles(1);
    check("st_wb_ena", {31'b0, wb_w_reg_ena}, 32'h0);
    check("st_stalls", 32'(stall_cnt - s0), 32'd0);

    // Back-to-back loads
    s0 = stall_cnt;
    r0 = req_cnt;
    issue(1, 32'h10, 32'h0, 5'd8, 0, 1, 1);
    check("b2b_addr0", dmem.dmem_addr, 32'h10);
    issue(1, 32'h14, 32'h0, 5'd9, 0, 1, 1);
    check("b2b_addr1", dmem.dmem_addr, 32'h14);
    check("b2b_req1", {31'b0, dmem.dmem_req}, 32'h1);
    bubbles(2);
    check("b2b_req_cycles", 32'(req_cnt - r0), 32'd2);
    check("b2b_stalls", 32'(stall_cnt - s0), 32'd0);

    // Write to x0 is suppressed
    issue(1, 32'h55, 32'h0, 5'd0, 0, 1, 0);
    check("x0_exm_ena", {31'b0, ex_mem_w_reg_ena}, 32'h0);
    bubbles(1);
    check("x0_wb_ena", {31'b0, wb_w_reg_ena}, 32'h0);

    // Reset mid-request, then a stray ack
    fixed_delay = 10;
    issue(1, 32'h20, 32'h0, 5'd4, 0, 1, 1);
    check("rst_req_before", {31'b0, dmem.dmem_req}, 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    wbq.delete();
    reqq.delete();
    check_quiet("rst_mid");
    force_ack = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    force_ack = 1'b0;
    check_quiet("stray_ack");
    fixed_delay = -1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 63));
      case (kind)
        0: bubbles(1);
        1: issue(1, $urandom, $urandom, 5'($urandom),
                 0, 1'($urandom), 0);
        2: issue(1, a, $urandom, 5'($urandom),
                 0, 1'($urandom_range(0, 3) != 0), 1);
        default: issue(1, a, $urandom, 5'($urandom),
                       1, 1'($urandom), 0);
      endcase
    end
    bubbles(4);
    check("wbq_drained", 32'(wbq.size()), 32'd0);
    check("reqq_drained", 32'(reqq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
